// File: rtl/add8u_err_sweeper.sv
// Exhaustive error characterizer for an unsigned approximate adder: walks every
// operand pair, compares against the exact sum and accumulates MAE/EP/WCE statistics.
module add8u_err_sweeper #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           hold,
  output logic [W-1:0]   dut_a,
  output logic [W-1:0]   dut_b,
  input  logic [W:0]     dut_o,
  output logic           busy,
  output logic           done,
  output logic [3*W:0]   sum_abs_err,
  output logic [2*W:0]   err_cnt,
  output logic [W:0]     wce,
  output logic [W-1:0]   wce_a,
  output logic [W-1:0]   wce_b
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t           state_r;
  logic [2*W-1:0]   idx_r;
  logic             s1_valid_r;
  logic [W:0]       s1_err_r;
  logic [W-1:0]     s1_a_r;
  logic [W-1:0]     s1_b_r;
  logic [W:0]       exact_s;
  logic [W:0]       err_s;
  logic             last_s;
  logic             s1_nz_s;

  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    logic [W:0] d;
    if (x >= y) begin
      d = x - y;
    end else begin
      d = y - x;
    end
    return d;
  endfunction

  // The operand registers are the index itself, so A varies fastest and IDLE shows zero.
  assign dut_a = idx_r[W-1:0];
  assign dut_b = idx_r[2*W-1:W];

  // Error of the vector currently presented to the adder under test.
  always_comb begin
    exact_s = {1'b0, dut_a} + {1'b0, dut_b};
    err_s   = abs_diff(exact_s, dut_o);
    last_s  = (idx_r == {(2*W){1'b1}});
    s1_nz_s = (s1_err_r != {(W+1){1'b0}});
  end

  // Sequencer, sample stage and result accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= {(2*W){1'b0}};
      s1_valid_r  <= 1'b0;
      s1_err_r    <= {(W+1){1'b0}};
      s1_a_r      <= {W{1'b0}};
      s1_b_r      <= {W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      sum_abs_err <= {(3*W+1){1'b0}};
      err_cnt     <= {(2*W+1){1'b0}};
      wce         <= {(W+1){1'b0}};
      wce_a       <= {W{1'b0}};
      wce_b       <= {W{1'b0}};
    end else begin
      done <= 1'b0;
      if (s1_valid_r) begin
        sum_abs_err <= sum_abs_err + {{(2*W){1'b0}}, s1_err_r};
        err_cnt     <= err_cnt + {{(2*W){1'b0}}, s1_nz_s};
        // Strict compare keeps the earliest vector on ties.
        if (s1_err_r > wce) begin
          wce   <= s1_err_r;
          wce_a <= s1_a_r;
          wce_b <= s1_b_r;
        end
      end
      case (state_r)
        S_IDLE: begin
          s1_valid_r <= 1'b0;
          if (start) begin
            state_r     <= S_RUN;
            busy        <= 1'b1;
            idx_r       <= {(2*W){1'b0}};
            sum_abs_err <= {(3*W+1){1'b0}};
            err_cnt     <= {(2*W+1){1'b0}};
            wce         <= {(W+1){1'b0}};
            wce_a       <= {W{1'b0}};
            wce_b       <= {W{1'b0}};
          end
        end
        S_RUN: begin
          if (!hold) begin
            s1_valid_r <= 1'b1;
            s1_err_r   <= err_s;
            s1_a_r     <= dut_a;
            s1_b_r     <= dut_b;
            if (last_s) begin
              state_r <= S_DRAIN;
              idx_r   <= {(2*W){1'b0}};
            end else begin
              idx_r <= idx_r + {{(2*W-1){1'b0}}, 1'b1};
            end
          end else begin
            s1_valid_r <= 1'b0;
          end
        end
        S_DRAIN: begin
          s1_valid_r <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          state_r    <= S_FIN;
        end
        S_FIN: begin
          s1_valid_r <= 1'b0;
          state_r    <= S_IDLE;
        end
        default: begin
          s1_valid_r <= 1'b0;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
